cheri_data_mem_responder: RTL and testbench

Memory-side responder for the CHERIoT core data interface: it terminates the req/gnt/rvalid protocol driven by the core, drives a single-port 33-bit-wide tagged SRAM with one-cycle read latency, enforces capability-tag clearing rules on writes, and flags out-of-range accesses as bus errors. It sits between the core's data port and the data RAM macro, and adds programmable grant wait states so the bench can stress core stall handling.

---
 rtl/cheri_mem_pkg.sv | 32 +++
 rtl/cheri_mem_wait_gen.sv | 59 +++++
 rtl/cheri_data_mem_responder.sv | 90 +++++++++
 tb/tb_cheri_data_mem_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cheri_mem_pkg.sv
// Shared definitions for the CHERIoT data/instruction memory responders:
// capability tag position, grant-FSM states and the byte-enable expander.
package cheri_mem_pkg;

  // Bit 32 of every memory word carries the capability tag.
  localparam int unsigned TagBit = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wait_state_e;

  // Expands 4 byte enables into a per-bit write mask covering the data bits.
  // The tag bit is left clear; the caller decides how the tag is written.
  function automatic logic [TagBit:0] be_to_mask(input logic [3:0] be);
    logic [TagBit:0] mask;
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

  // Mask with only the tag bit set.
  function automatic logic [TagBit:0] tag_mask();
    logic [TagBit:0] mask;
    mask         = '0;
    mask[TagBit] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/cheri_mem_wait_gen.sv
// Programmable grant wait-state generator shared by the memory responders.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no request in flight; zero-wait requests are granted here
//   WAIT  | counting down wait states; grant when cnt reaches 1
//
// The wait count is captured when the request is first seen and the request
// attributes are expected to stay stable until the grant; dropping the
// request while waiting abandons it without a grant.
module cheri_mem_wait_gen
  import cheri_mem_pkg::*;
(
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [3:0] wait_cycles,
  input  logic       req,
  output logic       gnt
);

  wait_state_e state;
  logic [3:0]  cnt;

  // Grant is combinational so a zero-wait request is accepted in the same
  // cycle; it is held off while reset is asserted.
  assign gnt = rstn_i & req &
               (((state == IDLE) && (wait_cycles == 4'd0)) ||
                ((state == WAIT) && (cnt == 4'd1)));

  // Grant FSM and wait-state down-counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req && (wait_cycles != 4'd0)) begin
            cnt   <= wait_cycles;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!req || (cnt == 4'd1)) begin
            cnt   <= 4'd0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          cnt   <= 4'd0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/cheri_data_mem_responder.sv
// Memory-side responder for the CHERIoT core data port. Terminates the
// req/gnt/rvalid handshake, drives a single-port tagged SRAM with one-cycle
// read latency, clears capability tags on non-capability writes and answers
// accesses outside the RAM window with a bus error.
module cheri_data_mem_responder
  import cheri_mem_pkg::*;
#(
  parameter logic [31:0] MemBase   = 32'h2004_0000,
  parameter int unsigned MemWords  = 16384,
  parameter int unsigned DataWidth = 33,
  parameter int unsigned AddrW     = $clog2(MemWords)
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [3:0]           wait_cycles_i,
  input  logic                 data_req_i,
  output logic                 data_gnt_o,
  output logic                 data_rvalid_o,
  input  logic                 data_we_i,
  input  logic                 data_is_cap_i,
  input  logic [3:0]           data_be_i,
  input  logic [31:0]          data_addr_i,
  input  logic [DataWidth-1:0] data_wdata_i,
  output logic [DataWidth-1:0] data_rdata_o,
  output logic                 data_err_o,
  output logic                 sram_cs_o,
  output logic                 sram_we_o,
  output logic [AddrW-1:0]     sram_addr_o,
  output logic [DataWidth-1:0] sram_wmask_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam logic [31:0] WinBytes = 32'(MemWords * 4);

  logic        gnt;
  logic        in_range;
  logic [31:0] offset;
  logic        rvalid_q;
  logic        err_q;
  logic        rd_q;
  logic        unused_offset;

  cheri_mem_wait_gen u_wait_gen (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .wait_cycles (wait_cycles_i),
    .req         (data_req_i),
    .gnt         (gnt)
  );

  assign data_gnt_o = gnt;

  // Window check: the lower bound guards against wrap-around of the offset.
  assign offset   = data_addr_i - MemBase;
  assign in_range = (data_addr_i >= MemBase) && (offset < WinBytes);

  // Addresses are word aligned and the window is a power of two, so only the
  // word-index slice of the offset reaches the SRAM.
  assign unused_offset = ^{offset[31:AddrW+2], offset[1:0]};

  assign sram_cs_o   = gnt & in_range;
  assign sram_we_o   = sram_cs_o & data_we_i;
  assign sram_addr_o = offset[AddrW+1:2];

  // Every in-range write rewrites the tag: capability writes store the
  // supplied tag, any other write clears it so partial overwrites can never
  // leave a forged capability behind.
  assign sram_wmask_o = sram_we_o ? (be_to_mask(data_be_i) | tag_mask()) : '0;
  assign sram_wdata_o = {data_is_cap_i & data_wdata_i[TagBit], data_wdata_i[TagBit-1:0]};

  // One response per grant, one cycle later; remember whether it carries
  // SRAM read data or an error.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rd_q     <= 1'b0;
    end else begin
      rvalid_q <= gnt;
      err_q    <= gnt & ~in_range;
      rd_q     <= gnt & in_range & ~data_we_i;
    end
  end

  assign data_rvalid_o = rvalid_q;
  assign data_err_o    = err_q;
  assign data_rdata_o  = rd_q ? sram_rdata_i : '0;

endmodule

// File: tb/tb_cheri_data_mem_responder.sv
// Self-checking bench for cheri_data_mem_responder: directed scenarios plus a
// randomized access mix, checked against a word-level memory model.
module tb_cheri_data_mem_responder;

  localparam logic [31:0] BASE  = 32'h2004_0000;
  localparam int          WORDS = 16384;
  localparam int          AW    = 14;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic [3:0]    wait_cycles_i = 4'd0;
  logic          data_req_i = 1'b0;
  logic          data_gnt_o;
  logic          data_rvalid_o;
  logic          data_we_i = 1'b0;
  logic          data_is_cap_i = 1'b0;
  logic [3:0]    data_be_i = 4'h0;
  logic [31:0]   data_addr_i = 32'h0;
  logic [32:0]   data_wdata_i = 33'h0;
  logic [32:0]   data_rdata_o;
  logic          data_err_o;
  logic          sram_cs_o;
  logic          sram_we_o;
  logic [AW-1:0] sram_addr_o;
  logic [32:0]   sram_wmask_o;
  logic [32:0]   sram_wdata_o;
  logic [32:0]   sram_rdata_i;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  cheri_data_mem_responder dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .wait_cycles_i (wait_cycles_i),
    .data_req_i    (data_req_i),
    .data_gnt_o    (data_gnt_o),
    .data_rvalid_o (data_rvalid_o),
    .data_we_i     (data_we_i),
    .data_is_cap_i (data_is_cap_i),
    .data_be_i     (data_be_i),
    .data_addr_i   (data_addr_i),
    .data_wdata_i  (data_wdata_i),
    .data_rdata_o  (data_rdata_o),
    .data_err_o    (data_err_o),
    .sram_cs_o     (sram_cs_o),
    .sram_we_o     (sram_we_o),
    .sram_addr_o   (sram_addr_o),
    .sram_wmask_o  (sram_wmask_o),
    .sram_wdata_o  (sram_wdata_o),
    .sram_rdata_i  (sram_rdata_i)
  );

  // External SRAM: bit-masked write, one-cycle registered read.
  bit [32:0] sram_mem [WORDS];
  bit [32:0] sram_q;
  always @(posedge clk_i) begin
    if (sram_cs_o === 1'b1) begin
      if (sram_we_o === 1'b1)
        sram_mem[sram_addr_o] <= (sram_mem[sram_addr_o] & ~sram_wmask_o) | (sram_wdata_o & sram_wmask_o);
      else
        sram_q <= sram_mem[sram_addr_o];
    end
  end
  assign sram_rdata_i = sram_q;

  // Reference model: what the core should see, keyed by word index.
  bit [32:0] ref_mem [int];

  function automatic bit ref_in_range(input bit [31:0] a);
    longint lo, hi, x;
    lo = longint'({32'b0, BASE});
    hi = lo + 4 * WORDS;
    x  = longint'({32'b0, a});
    return (x >= lo) && (x < hi);
  endfunction

  function automatic int ref_index(input bit [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic bit [32:0] ref_read(input bit [31:0] a);
    int idx;
    idx = ref_index(a);
    return ref_mem.exists(idx) ? ref_mem[idx] : 33'h0;
  endfunction

  function automatic void ref_write(input bit [31:0] a, input bit [3:0] be, input bit cap, input bit [32:0] wd);
    bit [32:0] w;
    w = ref_read(a);
    for (int i = 0; i < 4; i++)
      if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
    w[32] = cap ? wd[32] : 1'b0;
    ref_mem[ref_index(a)] = w;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access: raise req, wait for the grant (bounded), check the
  // grant latency and SRAM strobe, then check the response one cycle later.
  task automatic access(input bit we, input bit cap, input bit [3:0] be, input bit [31:0] addr,
                        input bit [32:0] wd, input bit [3:0] wc, input string tag,
                        output logic [32:0] rd_obs);
    int        lat;
    bit        inr;
    bit [32:0] exp_rd;
    inr    = ref_in_range(addr);
    exp_rd = (!we && inr) ? ref_read(addr) : 33'h0;
    @(negedge clk_i);
    data_req_i    = 1'b1;
    data_we_i     = we;
    data_is_cap_i = cap;
    data_be_i     = be;
    data_addr_i   = addr;
    data_wdata_i  = wd;
    wait_cycles_i = wc;
    lat = 0;
    #1;
    while (data_gnt_o !== 1'b1 && lat < 20) begin
      @(negedge clk_i);
      #1;
      lat++;
    end
    check({tag, ".gnt_lat"}, lat, wc);
    check({tag, ".cs"}, sram_cs_o, inr);
    if (inr) check({tag, ".sram_addr"}, sram_addr_o, ref_index(addr));
    @(negedge clk_i);
    data_req_i = 1'b0;
    #1;
    check({tag, ".rvalid"}, data_rvalid_o, 1'b1);
    check({tag, ".err"}, data_err_o, !inr);
    check({tag, ".rdata"}, data_rdata_o, exp_rd);
    rd_obs = data_rdata_o;
    if (we && inr) ref_write(addr, be, cap, wd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] rd;
    logic [32:0] exp_b2b [8];
    bit          bad;
    bit [31:0]   addr;
    int          r;

    // Reset values
    repeat (3) @(negedge clk_i);
    #1;
    check("rst.gnt", data_gnt_o, 1'b0);
    check("rst.rvalid", data_rvalid_o, 1'b0);
    check("rst.err", data_err_o, 1'b0);
    check("rst.rdata", data_rdata_o, 33'h0);
    check("rst.cs", sram_cs_o, 1'b0);
    check("rst.we", sram_we_o, 1'b0);
    @(negedge clk_i);
    rstn_i = 1'b1;

    // Capability write then read, zero wait states
    access(1'b1, 1'b1, 4'hF, BASE + 32'h10, 33'h1_DEAD_BEEF, 4'd0, "capw", rd);
    access(1'b0, 1'b0, 4'hF, BASE + 32'h10, 33'h0, 4'd0, "capr", rd);
    check("capr.const", rd, 33'h1_DEAD_BEEF);

    // Partial non-capability write clears the tag, keeps upper bytes
    access(1'b1, 1'b1, 4'hF, BASE + 32'h20, 33'h1_1234_5678, 4'd0, "tagw1", rd);
    access(1'b1, 1'b0, 4'b0001, BASE + 32'h20, 33'h1_0000_0055, 4'd0, "tagw2", rd);
    access(1'b0, 1'b1, 4'hF, BASE + 32'h20, 33'h0, 4'd0, "tagr", rd);
    check("tagr.const", rd, 33'h0_1234_5655);

    // Three wait states
    access(1'b0, 1'b0, 4'hF, BASE + 32'h10, 33'h0, 4'd3, "wait3", rd);

    // Request abandoned while waiting: no grant, strobe or response
    @(negedge clk_i);
    data_req_i    = 1'b1;
    data_we_i     = 1'b0;
    data_addr_i   = BASE + 32'h10;
    wait_cycles_i = 4'd3;
    #1;
    bad = (data_gnt_o !== 1'b0) || (sram_cs_o !== 1'b0);
    @(negedge clk_i);
    data_req_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      bad |= (data_gnt_o !== 1'b0) || (sram_cs_o !== 1'b0) || (data_rvalid_o !== 1'b0);
      @(negedge clk_i);
    end
    check("drop.quiet", bad, 1'b0);
    access(1'b0, 1'b0, 4'hF, BASE + 32'h20, 33'h0, 4'd0, "after_drop", rd);

    // Window boundaries
    access(1'b0, 1'b0, 4'hF, BASE + 32'(4 * WORDS), 33'h0, 4'd0, "oor_hi", rd);
    access(1'b0, 1'b0, 4'hF, BASE - 32'd4, 33'h0, 4'd0, "oor_lo", rd);
    access(1'b1, 1'b1, 4'hF, BASE + 32'(4 * (WORDS - 1)), 33'h1_CAFE_F00D, 4'd1, "last_w", rd);
    access(1'b0, 1'b0, 4'hF, BASE + 32'(4 * (WORDS - 1)), 33'h0, 4'd2, "last_r", rd);

    // Back-to-back zero-wait reads
    for (int i = 0; i < 8; i++)
      access(1'b1, 1'($urandom_range(0, 1)), 4'hF, BASE + 32'h100 + 32'(4 * i),
             {1'($urandom_range(0, 1)), 32'($urandom)}, 4'd0, "b2b_fill", rd);
    for (int i = 0; i < 8; i++) exp_b2b[i] = ref_read(BASE + 32'h100 + 32'(4 * i));
    @(negedge clk_i);
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        data_req_i    = 1'b1;
        data_we_i     = 1'b0;
        data_addr_i   = BASE + 32'h100 + 32'(4 * i);
        wait_cycles_i = 4'd0;
      end else begin
        data_req_i = 1'b0;
      end
      #1;
      if (i < 8) check($sformatf("b2b.gnt%0d", i), data_gnt_o, 1'b1);
      if (i > 0) begin
        check($sformatf("b2b.rvalid%0d", i - 1), data_rvalid_o, 1'b1);
        check($sformatf("b2b.rdata%0d", i - 1), data_rdata_o, exp_b2b[i-1]);
      end
      @(negedge clk_i);
    end
    #1;
    check("b2b.rvalid_end", data_rvalid_o, 1'b0);

    // Reset asserted while a grant is pending
    @(negedge clk_i);
    data_req_i    = 1'b1;
    data_we_i     = 1'b0;
    data_addr_i   = BASE + 32'h10;
    wait_cycles_i = 4'd0;
    #1;
    check("midrst.gnt_before", data_gnt_o, 1'b1);
    rstn_i     = 1'b0;
    data_req_i = 1'b0;
    @(negedge clk_i);
    #1;
    check("midrst.rvalid", data_rvalid_o, 1'b0);
    check("midrst.err", data_err_o, 1'b0);
    check("midrst.rdata", data_rdata_o, 33'h0);
    check("midrst.cs", sram_cs_o, 1'b0);
    check("midrst.gnt", data_gnt_o, 1'b0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    access(1'b0, 1'b0, 4'hF, BASE + 32'h10, 33'h0, 4'd0, "post_rst", rd);

    // Randomized mix of reads/writes, enables, tags, waits and addresses
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      addr = BASE + 32'(4 * WORDS) + 32'(4 * $urandom_range(0, 3));
      else if (r == 1) addr = BASE - 32'd4 - 32'(4 * $urandom_range(0, 3));
      else if (r == 2) addr = BASE + 32'(4 * (WORDS - 1));
      else             addr = BASE + 32'(4 * $urandom_range(0, 15));
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), addr,
             {1'($urandom_range(0, 1)), 32'($urandom)}, 4'($urandom_range(0, 3)), "rnd", rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
